pipe_shifter: RTL and testbench
===============================

# pipe_shifter

Parametrised, fully pipelined barrel shifter for the processor ALU. Generalises the fixed single-bit arithmetic right shift into a log2(WIDTH)-stage registered shifter supporting logical left, logical right, arithmetic right and (optionally) rotate-right by any amount. Every stage is registered, and the pipeline has a valid/ready handshake with global stall, so the execute stage can issue one shift per cycle and absorb writeback backpressure.

## Interface
- WIDTH, 32, datapath width in bits; power of two, 4 to 64.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand present
- in_ready  out  1  pipeline can accept an input this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHW  shift amount, 0 to WIDTH-1
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  shifted result

## Operation
- Stage k, for k = 0 to SHW-1, shifts by 2^k when shamt[k]=1; otherwise it passes the data unchanged.
- Each stage carries its data, the remaining shamt, op and a valid bit in registers.
- Fill bits per op:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: copies of the operand's original bit WIDTH-1 enter at the MSB.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- A shamt of 0 returns in_data unchanged for every op.
- SRA on a negative operand saturates at all-ones, never at zero.
- Global stall: stall = out_valid & ~out_ready.
  - When stall=1, no stage register updates.
  - When stall=0, all stages advance by one.
- in_ready = ~stall. This is combinational from out_valid/out_ready, with no combinational path from in_valid.
- An input transfers when in_valid & in_ready.
- A bubble (valid=0) advances like data when in_valid=0 and stall=0.
- An output transfers when out_valid & out_ready.
- Results leave in strict issue order; none are dropped or duplicated.
- Reset:
  - All stage valid bits clear asynchronously on reset_n low.
  - out_valid=0 and out_data=0 immediately.
  - in_ready=1 from the first cycle after reset_n rises.
  - Data in flight is discarded; no partial result emerges after reset release.

## Timing
- Latency is SHW cycles from input acceptance to out_valid: 5 for WIDTH=32, 3 for WIDTH=8.
- Throughput is one result per cycle when out_ready is held at 1.
- A stall holds every stage. out_data and out_valid remain stable while stalled.
- With input accepted and output taken in the same cycle, both transfers complete and the occupancy is unchanged.
- Capacity is SHW results in flight. There is no skid buffer; upstream must honour in_ready.
- The longest register-to-register logic path is one 2:1 mux level plus fill select.

## Configuration
- PIPE_SHIFTER_ROTATE_EN defined:
  - op 11 performs rotate-right.
  - Rotate-right by s equals (x >> s) | (x << (WIDTH-s)) for s>0.
- PIPE_SHIFTER_ROTATE_EN undefined:
  - op 11 decodes as SRL.
  - No rotate wrap-around logic is synthesised.
- All other behaviour and timing are identical with or without the macro.

## Test plan
- WIDTH=32, SRA 0x80000000 shamt 1 -> 0xC0000000 after 5 cycles; SRA 0x80000000 shamt 31 -> 0xFFFFFFFF; SRA 0x7FFFFFFF shamt 31 -> 0x00000000.
- SLL 0x00000001 shamt 31 -> 0x80000000; SRL 0xF0000000 shamt 4 -> 0x0F000000; any op on 0xDEADBEEF with shamt 0 -> 0xDEADBEEF.
- ROR 0x00000001 shamt 1 -> 0x80000000 and ROR 0x12345678 shamt 8 -> 0x78123456 with the macro defined; the same two stimuli give 0x00000000 and 0x00123456 with it undefined.
- Issue 10 back-to-back random ops with out_ready low on cycles 6-8:
  - in_ready drops on those cycles.
  - out_data holds while stalled.
  - All 10 results match the reference model in order, with no loss or duplication.
- Assert reset_n low for 1 cycle with 3 ops in flight:
  - out_valid=0 and out_data=0 immediately.
  - Nothing emerges for 5 cycles after release.
  - The next op issued returns the correct result after 5 cycles.
- WIDTH=8: SRA 0x80 shamt 7 -> 0xFF with latency 3; SLL 0x01 shamt 7 -> 0x80.

Source files
------------

// File: rtl/pipe_shifter_if.sv
`timescale 1ns/1ps
// Handshake bundle for pipe_shifter: operand/op/shift amount in, shifted result out.
interface pipe_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_shifter.sv
`timescale 1ns/1ps
// Pipelined barrel shifter, SHW registered stages (SLL/SRL/SRA; ROR with PIPE_SHIFTER_ROTATE_EN).
// Backpressure: global stall freezes every stage while out_valid & ~out_ready; in_ready = ~stall.
module pipe_shifter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  pipe_shifter_if.slave bus
);

  logic [SHW-1:0]                vld_q, vld_d, src_vld;
  logic [SHW-1:0][WIDTH-1:0]     dat_q, dat_d, src_dat;
  logic [SHW-1:0][SHW-1:0]       shamt_q, shamt_d, src_shamt;
  logic [SHW-1:0][1:0]           op_q, op_d, src_op;
  logic [1:0]                    in_op_dec;
  logic                          stall;
  logic                          unused_tail;

  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] op,
                                                   input int amt);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = d << amt;
      // SRA: the running MSB already equals the operand's original sign bit
      2'b10:   r = (d >> amt) | (~({WIDTH{1'b1}} >> amt) & {WIDTH{d[WIDTH-1]}});
`ifdef PIPE_SHIFTER_ROTATE_EN
      2'b11:   r = (d >> amt) | (d << (WIDTH - amt));
`endif
      default: r = d >> amt;
    endcase
    return r;
  endfunction

`ifdef PIPE_SHIFTER_ROTATE_EN
  assign in_op_dec = bus.in_op;
`else
  assign in_op_dec = (bus.in_op == 2'b11) ? 2'b01 : bus.in_op;
`endif

  assign stall         = vld_q[SHW-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_q[SHW-1];
  assign bus.out_data  = dat_q[SHW-1];

  // Stage k reads stage k-1's registers; stage 0 reads the input port.
  assign src_vld   = {vld_q[SHW-2:0],   bus.in_valid};
  assign src_dat   = {dat_q[SHW-2:0],   bus.in_data};
  assign src_shamt = {shamt_q[SHW-2:0], bus.in_shamt};
  assign src_op    = {op_q[SHW-2:0],    in_op_dec};

  assign unused_tail = ^{shamt_q[SHW-1], op_q[SHW-1]};

  always_comb begin
    vld_d   = vld_q;
    dat_d   = dat_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    if (!stall) begin
      for (int k = 0; k < SHW; k++) begin
        vld_d[k]   = src_vld[k];
        dat_d[k]   = src_shamt[k][0] ? stage_shift(src_dat[k], src_op[k], 1 << k)
                                     : src_dat[k];
        // Remaining shift amount: the next stage consumes the new bit 0
        shamt_d[k] = src_shamt[k] >> 1;
        op_d[k]    = src_op[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      dat_q   <= '0;
      shamt_q <= '0;
      op_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_pipe_shifter.sv
`timescale 1ns/1ps
// Bench for pipe_shifter: directed corner cases, random stream with stall window, mid-flight reset.
module tb_pipe_shifter;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pipe_shifter_if #(.WIDTH(32)) bus ();
  pipe_shifter_if #(.WIDTH(8))  bus8 ();

  pipe_shifter #(.WIDTH(32)) dut  (.clock(clock), .reset_n(reset_n), .bus(bus));
  pipe_shifter #(.WIDTH(8))  dut8 (.clock(clock), .reset_n(reset_n), .bus(bus8));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand value.
  function automatic logic [63:0] ref_shift(input int w, input logic [63:0] x,
                                            input int s, input logic [1:0] op);
    logic [63:0] mask;
    longint      v;
    mask = (64'd1 << w) - 64'd1;
    case (op)
      2'd0: return (x << s) & mask;
      2'd1: return x >> s;
      2'd2: begin
        v = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        return 64'(v >>> s) & mask;
      end
      default: begin
`ifdef PIPE_SHIFTER_ROTATE_EN
        if (s == 0) return x;
        return ((x >> s) | (x << (w - s))) & mask;
`else
        return x >> s;
`endif
      end
    endcase
  endfunction

  // Called at posedge+1: resolve this cycle's transfers, then advance one clock.
  task automatic step(output logic in_xfer);
    #1;
    in_xfer = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("seq_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
    end
    if (in_xfer)
      exp_q.push_back(32'(ref_shift(32, 64'(bus.in_data), int'(bus.in_shamt), bus.in_op)));
    @(posedge clock);
    #1;
  endtask

  task automatic directed(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input int s, input logic [31:0] exp);
    logic acc;
    int   lat;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_data   = x;
    bus.in_shamt  = 5'(s);
    bus.out_ready = 1'b1;
    step(acc);
    bus.in_valid = 1'b0;
    chk({tag, "_acc"}, 64'(acc), 64'd1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step(acc);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk(tag, 64'(bus.out_data), 64'(exp));
    step(acc);
  endtask

  task automatic directed8(input string tag, input logic [1:0] op, input logic [7:0] x,
                           input int s, input logic [7:0] exp);
    int lat;
    bus8.in_valid = 1'b1;
    bus8.in_op    = op;
    bus8.in_data  = x;
    bus8.in_shamt = 3'(s);
    @(posedge clock);
    #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk(tag, 64'(bus8.out_data), 64'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic rand_fields();
    bus.in_op    = 2'($urandom_range(0, 3));
    bus.in_data  = $urandom;
    bus.in_shamt = 5'($urandom_range(0, 31));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int          issued;
    int          n0;
    logic [31:0] held;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_shamt   = '0;
    bus.in_op      = '0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.in_shamt  = '0;
    bus8.in_op     = '0;
    bus8.out_ready = 1'b1;
    held           = '0;

    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    directed("sra_neg_1",   2'd2, 32'h8000_0000, 1,  32'hC000_0000);
    directed("sra_neg_31",  2'd2, 32'h8000_0000, 31, 32'hFFFF_FFFF);
    directed("sra_pos_31",  2'd2, 32'h7FFF_FFFF, 31, 32'h0000_0000);
    directed("sll_1_31",    2'd0, 32'h0000_0001, 31, 32'h8000_0000);
    directed("srl_f_4",     2'd1, 32'hF000_0000, 4,  32'h0F00_0000);
    for (int o = 0; o < 4; o++)
      directed("shamt0", 2'(o), 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
`ifdef PIPE_SHIFTER_ROTATE_EN
    directed("ror_1_1",     2'd3, 32'h0000_0001, 1,  32'h8000_0000);
    directed("ror_1234_8",  2'd3, 32'h1234_5678, 8,  32'h7812_3456);
`else
    directed("ror_1_1",     2'd3, 32'h0000_0001, 1,  32'h0000_0000);
    directed("ror_1234_8",  2'd3, 32'h1234_5678, 8,  32'h0012_3456);
`endif

    directed8("sra8_80_7", 2'd2, 8'h80, 7, 8'hFF);
    directed8("sll8_01_7", 2'd0, 8'h01, 7, 8'h80);

    // Ten back-to-back random ops, output refused on cycles 6-8.
    issued = 0;
    n0     = n_out;
    rand_fields();
    for (int c = 1; c <= 60 && (issued < 10 || exp_q.size() > 0); c++) begin
      bus.out_ready = !(c >= 6 && c <= 8);
      bus.in_valid  = (issued < 10);
      if (c >= 6 && c <= 8) begin
        #1;
        chk("in_ready_stall",  64'(bus.in_ready),  64'd0);
        chk("out_valid_stall", 64'(bus.out_valid), 64'd1);
        if (c == 6) held = bus.out_data;
        else        chk("hold_data", 64'(bus.out_data), 64'(held));
      end
      step(acc);
      if (acc) begin
        issued++;
        rand_fields();
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_count", 64'(n_out - n0), 64'd10);
    chk("rand_drain", 64'(exp_q.size()), 64'd0);

    // Reset with three ops in flight.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      step(acc);
    end
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_data",  64'(bus.out_data),  64'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_quiet", 64'(bus.out_valid), 64'd0);
      step(acc);
    end
    directed("post_rst_sra", 2'd2, 32'h8000_0000, 1, 32'hC000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
